stream_addr_gen: RTL and testbench

STREAM_ADDR_GEN -- requirements
Module: stream_addr_gen

---
 rtl/stream_addr_gen.sv | 161 ++++++++++++++++
 tb/tb_stream_addr_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stream_addr_gen.sv
// Streaming neighbour-address generator for a D2Q9-style lattice.
// On Start the node coordinate and the packed 9-direction velocity vectors
// are captured; the block then emits one beat per direction (0..8) with the
// periodically wrapped neighbour coordinate and its linear address.
//
// Handshake: a beat is transferred on a rising edge where Valid_Out=1 and
// Ready_In=1. While Valid_Out=1 and Ready_In=0 all beat fields hold stable,
// and Valid_Out never drops until the beat is taken.
module stream_addr_gen #(
  parameter int WIDTH = 576,
  parameter int NX    = 64,
  parameter int NY    = 64,
  parameter int XW    = $clog2(NX),
  parameter int YW    = $clog2(NY),
  parameter int AW    = $clog2(NX*NY)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [XW-1:0]           X_In,
  input  logic [YW-1:0]           Y_In,
  input  logic signed [WIDTH-1:0] Cx_In,
  input  logic signed [WIDTH-1:0] Cy_In,
  input  logic                    Ready_In,
  output logic                    Valid_Out,
  output logic [3:0]              Dir_Out,
  output logic [XW-1:0]           Xn_Out,
  output logic [YW-1:0]           Yn_Out,
  output logic [AW-1:0]           Addr_Out,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Err_Out,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [WIDTH-1:0]   cx_q, cy_q;
  logic [3:0]         dir_q;
  logic               err_q;

  logic [7:0]         cx_off, cy_off;
  logic [7:0]         cx_eff, cy_eff;
  logic               cx_bad, cy_bad, beat_bad;
  logic               x_in_bad, y_in_bad;
  logic [XW-1:0]      xn;
  logic [YW-1:0]      yn;
  logic [AW-1:0]      addr;
  logic               run;

  // Only -1, 0 and +1 are meaningful lattice offsets.
  function automatic logic offset_legal(input logic [7:0] v);
    return (v == 8'h00) || (v == 8'h01) || (v == 8'hFF);
  endfunction

  assign x_in_bad = (32'(X_In) >= NX);
  assign y_in_bad = (32'(Y_In) >= NY);
  assign run      = (state == RUN);

  // Pick the integer part (top 8 bits of the 8.56 word) of the current direction.
  always_comb begin
    cx_off = '0;
    cy_off = '0;
    for (int k = 0; k < 9; k++) begin
      if (dir_q == 4'(k)) begin
        cx_off = cx_q[WIDTH-1-64*k -: 8];
        cy_off = cy_q[WIDTH-1-64*k -: 8];
      end
    end
  end

  // Illegal offsets are flagged and then behave as zero for this beat.
  always_comb begin
    cx_bad   = !offset_legal(cx_off);
    cy_bad   = !offset_legal(cy_off);
    beat_bad = cx_bad || cy_bad;
    cx_eff   = cx_bad ? 8'h00 : cx_off;
    cy_eff   = cy_bad ? 8'h00 : cy_off;
  end

  // Periodic wrap of the neighbour coordinate and its row-major address.
  always_comb begin
    xn = x_q;
    if (cx_eff == 8'h01) begin
      xn = (x_q == XW'(NX-1)) ? '0 : x_q + XW'(1);
    end else if (cx_eff == 8'hFF) begin
      xn = (x_q == '0) ? XW'(NX-1) : x_q - XW'(1);
    end
    yn = y_q;
    if (cy_eff == 8'h01) begin
      yn = (y_q == YW'(NY-1)) ? '0 : y_q + YW'(1);
    end else if (cy_eff == 8'hFF) begin
      yn = (y_q == '0) ? YW'(NY-1) : y_q - YW'(1);
    end
    addr = AW'(AW'(yn) * AW'(NX)) + AW'(xn);
  end

  // Next-state logic: walk ends when direction 8 is handed off.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (Ready_In && dir_q == 4'd8) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, walk context capture, direction counter and sticky error.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
      cx_q  <= '0;
      cy_q  <= '0;
      dir_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (Start) begin
            x_q   <= x_in_bad ? '0 : X_In;
            y_q   <= y_in_bad ? '0 : Y_In;
            cx_q  <= Cx_In;
            cy_q  <= Cy_In;
            dir_q <= '0;
            err_q <= x_in_bad || y_in_bad;
          end
        end
        RUN: begin
          if (beat_bad) err_q <= 1'b1;
          if (Ready_In && dir_q != 4'd8) dir_q <= dir_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Beat fields are only driven while a beat is on offer; zero otherwise.
  always_comb begin
    Valid_Out = run;
    Dir_Out   = run ? dir_q : '0;
    Xn_Out    = run ? xn    : '0;
    Yn_Out    = run ? yn    : '0;
    Addr_Out  = run ? addr  : '0;
    Busy      = (state != IDLE);
    Done      = (state == DONE);
    Err_Out   = err_q || (run && beat_bad);
    dbg_state = state;
  end

endmodule

// File: tb/tb_stream_addr_gen.sv
// Directed bench for stream_addr_gen: basic walk, wrap, backpressure,
// illegal component, mid-walk reset and Start held high.
module tb_stream_addr_gen;

  localparam int NX = 64;
  localparam int NY = 64;

  logic         clk;
  logic         reset;
  logic         start;
  logic [5:0]   x_in, y_in;
  logic [575:0] cx_in, cy_in;
  logic         ready_in;
  logic         valid_out;
  logic [3:0]   dir_out;
  logic [5:0]   xn_out, yn_out;
  logic [11:0]  addr_out;
  logic         busy, done, err_out;
  logic [1:0]   dbg_state;

  int n_chk = 0;
  int n_err = 0;

  int cx_b[9]  = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  int cy_b[9]  = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
  int ex_b[9]  = '{10, 11, 10, 9, 10, 11, 9, 9, 11};
  int ey_b[9]  = '{20, 20, 21, 20, 19, 21, 21, 19, 19};
  int ex_w[9]  = '{63, 0, 63, 62, 63, 0, 62, 62, 0};
  int ey_w[9]  = '{0, 0, 1, 0, 63, 1, 1, 63, 63};
  int ex_e[9]  = '{10, 11, 10, 9, 10, 10, 9, 9, 11};

  logic [575:0] cx_v, cy_v, cx_err;

  stream_addr_gen dut (
    .Clk(clk), .Reset(reset), .Start(start),
    .X_In(x_in), .Y_In(y_in), .Cx_In(cx_in), .Cy_In(cy_in),
    .Ready_In(ready_in), .Valid_Out(valid_out), .Dir_Out(dir_out),
    .Xn_Out(xn_out), .Yn_Out(yn_out), .Addr_Out(addr_out),
    .Busy(busy), .Done(done), .Err_Out(err_out), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [575:0] pack(input int v[9]);
    logic [575:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[575-64*k -: 64] = {8'(v[k]), 56'h00_0000_0000_00A5};
    return r;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 32'(valid_out), 0);
    check({tag, "_dir"},   32'(dir_out),   0);
    check({tag, "_xn"},    32'(xn_out),    0);
    check({tag, "_yn"},    32'(yn_out),    0);
    check({tag, "_addr"},  32'(addr_out),  0);
    check({tag, "_busy"},  32'(busy),      0);
    check({tag, "_done"},  32'(done),      0);
    check({tag, "_err"},   32'(err_out),   0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One full walk; inputs are disturbed after capture, beats checked every cycle.
  task automatic run_walk(input int x0, input int y0,
                          input logic [575:0] cx, input logic [575:0] cy,
                          input int ex[9], input int ey[9],
                          input int stall_k, input int err_from, input bit hold_start);
    int k, cycles, held;
    bit rdy;
    logic exp_err;
    @(negedge clk);
    x_in = 6'(x0); y_in = 6'(y0); cx_in = cx; cy_in = cy;
    start = 1'b1; ready_in = 1'b1;
    k = 0; cycles = 0; held = 0;
    while (k < 9 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (!hold_start) start = 1'b0;
      x_in = 6'(x0 + 3); y_in = 6'(y0 + 5); cx_in = '0; cy_in = '0;
      exp_err = (k >= err_from);
      check("valid", 32'(valid_out), 1);
      check("busy",  32'(busy),      1);
      check("done_early", 32'(done), 0);
      check("dir",   32'(dir_out),   32'(k));
      check("xn",    32'(xn_out),    32'(ex[k]));
      check("yn",    32'(yn_out),    32'(ey[k]));
      check("addr",  32'(addr_out),  32'(ey[k] * NX + ex[k]));
      check("err",   32'(err_out),   32'(exp_err));
      rdy = !(k == stall_k && held < 3);
      if (k == stall_k) held++;
      ready_in = rdy;
      if (rdy) k++;
    end
    check("beats", 32'(k), 9);
    if (stall_k < 9) check("hold_cycles", 32'(held), 4);
    exp_err = (err_from < 9);
    @(negedge clk);
    check("done_pulse", 32'(done),      1);
    check("done_valid", 32'(valid_out), 0);
    check("done_busy",  32'(busy),      1);
    check("done_err",   32'(err_out),   32'(exp_err));
    @(negedge clk);
    check("idle_done",  32'(done),      0);
    check("idle_busy",  32'(busy),      0);
    check("idle_valid", 32'(valid_out), 0);
    check("idle_err",   32'(err_out),   32'(exp_err));
    check("idle_state", 32'(dbg_state), 0);
    if (hold_start) begin
      @(negedge clk);
      start = 1'b0;
      check("restart_valid", 32'(valid_out), 1);
      check("restart_dir",   32'(dir_out),   0);
      do_reset();
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b0; start = 1'b1; ready_in = 1'b1;
    x_in = '0; y_in = '0; cx_in = '0; cy_in = '0;
    cx_v = pack(cx_b);
    cy_v = pack(cy_b);
    cx_err = cx_v;
    cx_err[575-320 -: 64] = 64'h0200_0000_0000_0000;

    // Power-on reset with Start asserted: Start must be ignored.
    repeat (3) @(negedge clk);
    check_idle_zero("por");
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    check("por_nostart", 32'(valid_out), 0);

    // Basic walk, wrap walk, backpressure on beat 2.
    run_walk(10, 20, cx_v, cy_v, ex_b, ey_b, 99, 9, 1'b0);
    run_walk(63, 0,  cx_v, cy_v, ex_w, ey_w, 99, 9, 1'b0);
    run_walk(10, 20, cx_v, cy_v, ex_b, ey_b, 2,  9, 1'b0);

    // Illegal cx slot 5, then a fresh walk clears the sticky error.
    run_walk(10, 20, cx_err, cy_v, ex_e, ey_b, 99, 5, 1'b0);
    run_walk(10, 20, cx_v,   cy_v, ex_b, ey_b, 99, 9, 1'b0);

    // Reset while beat 4 is on offer, with Start high in the same cycle.
    @(negedge clk);
    x_in = 6'd10; y_in = 6'd20; cx_in = cx_v; cy_in = cy_v;
    start = 1'b1; ready_in = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("rst_pre_dir", 32'(dir_out), 4);
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    check_idle_zero("rst_mid");
    reset = 1'b1; start = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || valid_out) seen = 1'b1;
    end
    check("rst_no_beats", 32'(seen), 0);
    run_walk(10, 20, cx_v, cy_v, ex_b, ey_b, 99, 9, 1'b0);

    // Start held high for the whole walk.
    run_walk(10, 20, cx_v, cy_v, ex_b, ey_b, 99, 9, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
